// File: rtl/blur_result_writer.sv
// rtl/blur_result_writer.sv - buffers blur results and issues addressed frame-buffer writes
// Counts one IMG_W*IMG_H frame and pulses o_frame_done when the last word has left.

module blur_result_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
endmodule

module blur_result_writer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_result_vld,
  input  logic [DATA_W-1:0] i_result_data,
  output logic              o_result_busy,
  output logic              o_wr_vld,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_busy,
  output logic              o_active,
  output logic              o_frame_done
);
  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic              frame_done;
  logic              fifo_empty;
  logic              fifo_full;
  logic              accept;
  logic              xfer;

  // Busy depends only on registered state so upstream never sees a vld->busy loop.
  assign o_result_busy = (state != RUN) || fifo_full;
  assign accept        = i_result_vld && !o_result_busy;
  assign o_wr_vld      = !fifo_empty && ((state == RUN) || (state == DRAIN));
  assign xfer          = o_wr_vld && !i_wr_busy;
  assign o_wr_addr     = base + ADDR_W'(out_cnt);
  assign o_active      = (state != IDLE);
  assign o_frame_done  = frame_done;

  blur_result_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (accept),
    .push_data (i_result_data),
    .pop       (xfer),
    .head      (o_wr_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      base       <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (xfer) out_cnt <= out_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (i_start) begin
            state   <= RUN;
            base    <= i_base_addr;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if (in_cnt == N_C - CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && (out_cnt == N_C)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          frame_done <= 1'b0;
        end
      endcase
    end
  end
endmodule
